// File: rtl/retro_uart_pkg.sv
// Purpose : shared UART definitions (bit timing default, FSM encodings, helpers) for TX and RX.
// Latency : n/a (package).
// Backpressure: n/a (package).
package retro_uart_pkg;

  // Default clocks-per-bit minus one: 104 clocks per bit.
  localparam logic [11:0] BIT_END_COUNT_DEF = 12'd103;

  // Receiver bit-level states.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  // Transmitter bit-level states, kept here so both directions share one encoding table.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Mid-bit sample point used to qualify a start bit.
  function automatic logic [11:0] half_bit(input logic [11:0] end_count);
    return end_count >> 1;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Purpose : bit-level UART receiver: 2-flop synchronizer, start/data/stop FSM, LSB-first shifter.
// Latency : byte_vld pulses on the edge that samples a good stop bit.
// Backpressure: none; the consumer must accept byte_vld in the cycle it is high.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   rxd              - asynchronous serial line, idle high
//   byte_vld/dat     - one-cycle strobe with the received byte
//   frame_err_pulse  - one-cycle strobe when the stop bit is sampled low
module uart_rx_core
  import retro_uart_pkg::*;
#(
  parameter logic [11:0] BIT_END_COUNT = BIT_END_COUNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       frame_err_pulse
);

  localparam logic [11:0] HALF_COUNT = half_bit(BIT_END_COUNT);

  logic        rx_meta;
  logic        rxs;
  rx_state_t   state;
  logic [11:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RX_IDLE;
      bit_cnt         <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      byte_vld        <= 1'b0;
      byte_dat        <= '0;
      frame_err_pulse <= 1'b0;
    end else begin
      byte_vld        <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
          if (!rxs) state <= RX_START;
        end

        // Re-check the line half a bit in; a high line here was a glitch.
        RX_START: begin
          if (bit_cnt == HALF_COUNT) begin
            bit_cnt <= '0;
            state   <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 12'd1;
          end
        end

        // Counter was zeroed at mid-start, so each full count lands mid-bit.
        RX_DATA: begin
          if (bit_cnt == BIT_END_COUNT) begin
            bit_cnt <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 12'd1;
          end
        end

        RX_STOP: begin
          if (bit_cnt == BIT_END_COUNT) begin
            bit_cnt <= '0;
            if (rxs) begin
              byte_vld <= 1'b1;
              byte_dat <= shift;
              state    <= RX_IDLE;
            end else begin
              frame_err_pulse <= 1'b1;
              state           <= RX_BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + 12'd1;
          end
        end

        // Line held low past the stop bit: wait for it to return high before hunting again.
        RX_BREAK: begin
          bit_cnt <= '0;
          if (rxs) state <= RX_IDLE;
        end

        default: begin
          state   <= RX_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// Purpose : CPU-facing UART receive port: bit receiver, show-ahead byte FIFO, sticky error flags.
// Latency : a received byte is visible on rx_data/rx_valid one cycle after its stop-bit sample.
// Backpressure: none toward the line; a byte arriving at a full FIFO (no pop that cycle) is dropped and flagged.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rxd                 - asynchronous serial line, idle high
//   rd_en               - pop one byte (ignored when empty)
//   clr_err             - clear sticky flags (a same-cycle set wins)
//   rx_data / rx_valid  - head of FIFO and not-empty
//   rx_full             - FIFO holds 2^ADR_WIDTH bytes
//   overrun, frame_err  - sticky error flags
module uart_rx_port
  import retro_uart_pkg::*;
#(
  parameter logic [11:0] BIT_END_COUNT = BIT_END_COUNT_DEF,
  parameter int          ADR_WIDTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int DEPTH = 1 << ADR_WIDTH;
  localparam logic [ADR_WIDTH:0] PTR_ONE = {{ADR_WIDTH{1'b0}}, 1'b1};

  logic                 byte_vld;
  logic [7:0]           byte_dat;
  logic                 frame_err_pulse;

  logic [7:0]           mem [DEPTH];
  logic [ADR_WIDTH:0]   wr_ptr;
  logic [ADR_WIDTH:0]   rd_ptr;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  uart_rx_core #(
    .BIT_END_COUNT(BIT_END_COUNT)
  ) u_core (
    .clk             (clk),
    .rst             (rst),
    .rxd             (rxd),
    .byte_vld        (byte_vld),
    .byte_dat        (byte_dat),
    .frame_err_pulse (frame_err_pulse)
  );

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADR_WIDTH] != rd_ptr[ADR_WIDTH]) &&
                 (wr_ptr[ADR_WIDTH-1:0] == rd_ptr[ADR_WIDTH-1:0]);

  assign pop  = rd_en & ~empty;
  // A same-cycle pop frees the slot being written, so a full FIFO still accepts.
  assign push = byte_vld & (~full | pop);
  assign drop = byte_vld & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADR_WIDTH-1:0]] <= byte_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Set has priority over clear so an event coinciding with clr_err is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;

      if (frame_err_pulse) frame_err <= 1'b1;
      else if (clr_err)    frame_err <= 1'b0;
    end
  end

  assign rx_valid = ~empty;
  assign rx_full  = full;
  // Forced to zero when empty so reset and drained states present a clean bus.
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[ADR_WIDTH-1:0]];

endmodule

// File: tb/tb_uart_rx_port.sv
module tb_uart_rx_port;

  localparam int BIT_CLKS = 104;
  // Edges from driving the start bit to the stop-bit sample: 2 synchronizer flops + 1 idle
  // detect, 52 edges to the mid-start check, then 8 data bits and the stop bit.
  localparam int STOP_EDGE = 3 + 52 + 9 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic       overrun;
  logic       frame_err;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] exp_q[$];
  bit         auto_read = 1'b0;
  bit         man_rd    = 1'b0;
  int         rd_pct    = 100;

  uart_rx_port #(
    .BIT_END_COUNT (12'd103),
    .ADR_WIDTH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_full   (rx_full),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial frame: start, 8 data bits LSB first, stop. stop_low>0 holds the stop bit low that
  // many bit times. The expected byte is queued up front; FIFO order keeps it correct.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input bit exp_push);
    if (exp_push) exp_q.push_back(b);
    rxd = 1'b0;
    tick(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(BIT_CLKS);
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      tick(BIT_CLKS * stop_low);
      rxd = 1'b1;
      tick(BIT_CLKS);
    end else begin
      rxd = 1'b1;
      tick(BIT_CLKS);
    end
  endtask

  task automatic drain(input string name);
    auto_read = 1'b1;
    rd_pct    = 100;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || rx_valid); i++) tick(1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_valid_low"}, rx_valid, 0);
    auto_read = 1'b0;
    tick(2);
  endtask

  // Monitor/reader: every pop compares the head byte against the scoreboard queue.
  initial begin
    rd_en = 1'b0;
    forever begin
      logic do_pop;
      @(negedge clk);
      do_pop = man_rd || (auto_read && rx_valid && ($urandom_range(99) < rd_pct));
      if (rst) do_pop = 1'b0;
      if (do_pop && rx_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL pop_unexpected: got byte %0h with nothing expected", rx_data);
        end else begin
          check("pop_data", rx_data, exp_q.pop_front());
        end
      end
      rd_en = do_pop;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rxd = 1'b1; clr_err = 1'b0;
    tick(5);
    check("rst_valid", rx_valid, 0);
    check("rst_full", rx_full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_data", rx_data, 8'h00);
    rst = 1'b0;
    tick(10);

    // Good frame 0x55 and exact push timing.
    fork
      send_frame(8'h55, 0, 1'b1);
      begin
        tick(STOP_EDGE);
        check("valid_at_stop_edge", rx_valid, 0);
        tick(1);
        check("valid_after_stop_edge", rx_valid, 1);
        check("data_55", rx_data, 8'h55);
      end
    join
    check("f55_overrun", overrun, 0);
    check("f55_frame_err", frame_err, 0);
    drain("f55");

    // 40-clock low glitch must be rejected.
    rxd = 1'b0;
    tick(40);
    rxd = 1'b1;
    tick(300);
    check("glitch_valid", rx_valid, 0);
    check("glitch_overrun", overrun, 0);
    check("glitch_frame_err", frame_err, 0);

    // Fill with 0x00..0x10 and no reads: the 17th byte must be dropped.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 0, exp_q.size() < 16);
      if (i == 14) check("full_after_15", rx_full, 0);
      if (i == 15) begin
        check("full_after_16", rx_full, 1);
        check("no_overrun_at_16", overrun, 0);
      end
    end
    check("overrun_after_17", overrun, 1);
    check("full_after_17", rx_full, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("overrun_cleared", overrun, 0);

    // Push 0x7E into a full FIFO while popping in the same cycle.
    fork
      send_frame(8'h7E, 0, 1'b1);
      begin
        tick(STOP_EDGE);
        man_rd = 1'b1;
        tick(1);
        man_rd = 1'b0;
      end
    join
    check("pushpop_full", rx_full, 1);
    check("pushpop_overrun", overrun, 0);
    check("pushpop_model_occ", exp_q.size(), 16);
    drain("full");

    // Stop bit held low: frame error wins over a coincident clear, nothing is pushed.
    fork
      send_frame(8'hA3, 3, 1'b0);
      begin
        tick(STOP_EDGE);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ferr_set_wins", frame_err, 1);
      end
    join
    check("ferr_nothing_pushed", rx_valid, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ferr_cleared", frame_err, 0);
    send_frame(8'h3C, 0, 1'b1);
    check("after_ferr_valid", rx_valid, 1);
    check("after_ferr_flag", frame_err, 0);
    drain("f3c");

    // Reset during data bit 4 of a frame abandons it.
    rxd = 1'b0;
    tick(BIT_CLKS * 5);
    rxd = 1'b1;
    tick(50);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(300);
    check("midrst_valid", rx_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_data", rx_data, 8'h00);
    send_frame(8'hC9, 0, 1'b1);
    drain("fc9");

    // Random bytes with random gaps and random reader pacing.
    auto_read = 1'b1;
    rd_pct    = 25;
    for (int i = 0; i < 12; i++) begin
      send_frame(8'($urandom), 0, 1'b1);
      tick($urandom_range(0, 20));
    end
    drain("rand");
    check("rand_overrun", overrun, 0);
    check("rand_frame_err", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
